// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller:
// opcodes, FSM state encodings, ALU function codes and PC source codes.
package mcpu_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // FSM states; HALT is tracked by a separate flag and reports as ID
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;

    // PC source select codes
    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    // ALU function required by an opcode; non-ALU opcodes fall back to add
    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        logic [2:0] res;
        case (op)
            OP_SUB, OP_BEQ: res = ALU_SUB;
            OP_SLT:         res = ALU_SLT;
            OP_OR, OP_ORI:  res = ALU_OR;
            OP_AND:         res = ALU_AND;
            default:        res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> instruction-class decoder.
module ctrl_decode
    import mcpu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    output logic           is_rtype_o,
    output logic           is_alu_o,
    output logic           is_ls_o,
    output logic           is_branch_o,
    output logic           is_jump_o,
    output logic           is_illegal_o
);

    // Classify the opcode; anything not in the instruction set is illegal
    always_comb begin
        is_rtype_o   = 1'b0;
        is_alu_o     = 1'b0;
        is_ls_o      = 1'b0;
        is_branch_o  = 1'b0;
        is_jump_o    = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: begin
                is_rtype_o = 1'b1;
                is_alu_o   = 1'b1;
            end
            OP_ADDI, OP_ORI: is_alu_o    = 1'b1;
            OP_SW, OP_LW:    is_ls_o     = 1'b1;
            OP_BEQ:          is_branch_o = 1'b1;
            OP_J, OP_JR, OP_JAL: is_jump_o = 1'b1;
            OP_HALT:         is_illegal_o = 1'b0;
            default:         is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EXE/MEM/WB per opcode and
// drives PC, IR, register file, ALU and data-memory controls.
module multi_cycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           RegWre,
    output logic           WrRegData,
    output logic           RegOut,
    output logic           ALUSrcB,
    output logic           ExtSel,
    output logic [2:0]     ALUOp,
    output logic [1:0]     PCSrc,
    output logic           mRD,
    output logic           mWR,
    output logic           DBDataSrc,
    output logic [STW-1:0] state,
    output logic           instr_done
);

    state_e state_q, state_d;
    logic   halt_q, halt_d;

    logic is_rtype_s, is_alu_s, is_ls_s, is_branch_s, is_jump_s, is_illegal_s;
    logic is_lw_s, is_jal_s, is_jr_s, is_halt_s, is_ori_s, imm_src_s;
    logic active_s;

    logic       pcwre_s, irwre_s, regwre_s, wrregdata_s, regout_s;
    logic       alusrcb_s, extsel_s, mrd_s, mwr_s, dbsrc_s, done_s;
    logic [2:0] aluop_s;
    logic [1:0] pcsrc_s;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode_i     (opcode),
        .is_rtype_o   (is_rtype_s),
        .is_alu_o     (is_alu_s),
        .is_ls_o      (is_ls_s),
        .is_branch_o  (is_branch_s),
        .is_jump_o    (is_jump_s),
        .is_illegal_o (is_illegal_s)
    );

    assign is_lw_s   = (opcode == OP_LW);
    assign is_jal_s  = (opcode == OP_JAL);
    assign is_jr_s   = (opcode == OP_JR);
    assign is_halt_s = (opcode == OP_HALT);
    assign is_ori_s  = (opcode == OP_ORI);
    assign imm_src_s = (opcode == OP_ADDI) || is_ori_s || is_ls_s;

    // Opcode-driven datapath controls are only meaningful from ID to WB
    assign active_s = (state_q != S_IF) && !halt_q;

    // State and halt flag registers; reset returns to IF at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic; halt parks the FSM in ID with the halt flag set
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (halt_q) begin
            state_d = S_ID;
            halt_d  = 1'b1;
        end else begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    if (is_alu_s) begin
                        state_d = S_EXE_AL;
                    end else if (is_ls_s) begin
                        state_d = S_EXE_LS;
                    end else if (is_branch_s) begin
                        state_d = S_EXE_BR;
                    end else if (is_halt_s) begin
                        state_d = S_ID;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = S_IF;
                    end
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_WB_AL:  state_d = S_IF;
                S_EXE_LS: state_d = S_MEM;
                S_MEM:    state_d = is_lw_s ? S_WB_LD : S_IF;
                S_WB_LD:  state_d = S_IF;
                S_EXE_BR: state_d = S_IF;
                default:  state_d = S_IF;
            endcase
        end
    end

    // Control outputs from state and opcode, before reset qualification
    always_comb begin
        pcwre_s     = 1'b0;
        irwre_s     = 1'b0;
        regwre_s    = 1'b0;
        wrregdata_s = 1'b1;
        regout_s    = 1'b0;
        alusrcb_s   = 1'b0;
        extsel_s    = 1'b1;
        aluop_s     = ALU_ADD;
        pcsrc_s     = PC_NEXT;
        mrd_s       = 1'b0;
        mwr_s       = 1'b0;
        dbsrc_s     = 1'b0;
        done_s      = 1'b0;

        if (active_s) begin
            regout_s  = is_rtype_s;
            alusrcb_s = imm_src_s;
            extsel_s  = !is_ori_s;
            aluop_s   = alu_op_of(opcode);
        end else begin
            irwre_s = (state_q == S_IF) && !halt_q;
        end

        if (!halt_q) begin
            case (state_q)
                S_ID: begin
                    if (is_jump_s || is_illegal_s) begin
                        done_s = 1'b1;
                        if (is_jal_s) begin
                            regwre_s    = 1'b1;
                            wrregdata_s = 1'b0;
                            pcsrc_s     = PC_JUMP;
                        end else if (is_jr_s) begin
                            pcsrc_s = PC_RS;
                        end else if (is_jump_s) begin
                            pcsrc_s = PC_JUMP;
                        end else begin
                            pcsrc_s = PC_NEXT;
                        end
                    end else begin
                        done_s = 1'b0;
                    end
                end
                S_EXE_BR: begin
                    done_s  = 1'b1;
                    pcsrc_s = zero ? PC_BRANCH : PC_NEXT;
                end
                S_MEM: begin
                    if (is_lw_s) begin
                        mrd_s   = 1'b1;
                        dbsrc_s = 1'b1;
                    end else begin
                        mwr_s  = 1'b1;
                        done_s = 1'b1;
                    end
                end
                S_WB_LD: begin
                    regwre_s = 1'b1;
                    dbsrc_s  = 1'b1;
                    done_s   = 1'b1;
                end
                S_WB_AL: begin
                    regwre_s = 1'b1;
                    done_s   = 1'b1;
                end
                default: done_s = 1'b0;
            endcase
        end else begin
            done_s = 1'b0;
        end

        pcwre_s = done_s;
    end

    // Every output is forced low while reset is held
    assign PCWre      = rst_n & pcwre_s;
    assign IRWre      = rst_n & irwre_s;
    assign RegWre     = rst_n & regwre_s;
    assign WrRegData  = rst_n & wrregdata_s;
    assign RegOut     = rst_n & regout_s;
    assign ALUSrcB    = rst_n & alusrcb_s;
    assign ExtSel     = rst_n & extsel_s;
    assign ALUOp      = rst_n ? aluop_s : 3'b000;
    assign PCSrc      = rst_n ? pcsrc_s : 2'b00;
    assign mRD        = rst_n & mrd_s;
    assign mWR        = rst_n & mwr_s;
    assign DBDataSrc  = rst_n & dbsrc_s;
    assign instr_done = rst_n & done_s;
    assign state      = rst_n ? state_q : S_IF;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: the driver pushes the hand-computed
// per-cycle output vector of each instruction; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] T_ADD  = 6'b000000;
    localparam logic [5:0] T_AND  = 6'b010001;
    localparam logic [5:0] T_ORI  = 6'b010010;
    localparam logic [5:0] T_SLT  = 6'b100110;
    localparam logic [5:0] T_SW   = 6'b110000;
    localparam logic [5:0] T_LW   = 6'b110001;
    localparam logic [5:0] T_BEQ  = 6'b110100;
    localparam logic [5:0] T_J    = 6'b111000;
    localparam logic [5:0] T_JR   = 6'b111001;
    localparam logic [5:0] T_JAL  = 6'b111010;
    localparam logic [5:0] T_HALT = 6'b111111;
    localparam logic [5:0] T_ILL  = 6'b101010;

    // flag order: PCWre IRWre RegWre WrRegData RegOut ALUSrcB ExtSel
    localparam logic [6:0] F_IF = 7'b0101001;
    // mem order: mRD mWR DBDataSrc instr_done

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre, IRWre, RegWre, WrRegData, RegOut, ALUSrcB, ExtSel;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
    logic       mRD, mWR, DBDataSrc, instr_done;
    logic [2:0] state;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    multi_cycle_ctrl #(.OPW(6), .STW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .PCWre      (PCWre),
        .IRWre      (IRWre),
        .RegWre     (RegWre),
        .WrRegData  (WrRegData),
        .RegOut     (RegOut),
        .ALUSrcB    (ALUSrcB),
        .ExtSel     (ExtSel),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .mRD        (mRD),
        .mWR        (mWR),
        .DBDataSrc  (DBDataSrc),
        .state      (state),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected vector per clock while the scoreboard holds entries
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [18:0] act;
            e   = sb_q.pop_front();
            act = {state, PCWre, IRWre, RegWre, WrRegData, RegOut, ALUSrcB, ExtSel,
                   ALUOp, PCSrc, mRD, mWR, DBDataSrc, instr_done};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got st=%b f=%b alu=%b pc=%b m=%b, want st=%b f=%b alu=%b pc=%b m=%b",
                         e.tag, act[18:16], act[15:9], act[8:6], act[5:4], act[3:0],
                         e.v[18:16], e.v[15:9], e.v[8:6], e.v[5:4], e.v[3:0]);
            end
        end
    end

    task automatic ex(input string tag, input logic [2:0] st, input logic [6:0] f,
                      input logic [2:0] a, input logic [1:0] p, input logic [3:0] m);
        exp_t e;
        e.v   = {st, f, a, p, m};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input string name, input logic [5:0] op, input logic z);
        opcode = op;
        zero   = z;
        ex({name, ".IF"}, 3'b000, F_IF, 3'b000, 2'b00, 4'b0000);
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++)
            ex("reset", 3'b000, 7'b0000000, 3'b000, 2'b00, 4'b0000);
        run(n);
        rst_n = 1'b1;
    endtask

    // Four-cycle ALU instruction: IF, ID, EXE_AL, WB_AL
    task automatic alu_instr(input string name, input logic [5:0] op,
                             input logic [6:0] f, input logic [2:0] a);
        start(name, op, 1'b0);
        ex({name, ".ID"}, 3'b001, f, a, 2'b00, 4'b0000);
        ex({name, ".EXE"}, 3'b110, f, a, 2'b00, 4'b0000);
        ex({name, ".WB"}, 3'b111, f | 7'b1010000, a, 2'b00, 4'b0001);
        run(4);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        run(2);
        rst_n = 1'b1;

        // add end to end
        alu_instr("add", T_ADD, 7'b0001101, 3'b000);

        // add interrupted by a 3-cycle reset entering EXE_AL, then restarted
        start("add_rst", T_ADD, 1'b0);
        ex("add_rst.ID", 3'b001, 7'b0001101, 3'b000, 2'b00, 4'b0000);
        run(2);
        hold_reset(3);
        alu_instr("add_after_rst", T_ADD, 7'b0001101, 3'b000);

        // lw: 5 cycles
        start("lw", T_LW, 1'b0);
        ex("lw.ID",  3'b001, 7'b0001011, 3'b000, 2'b00, 4'b0000);
        ex("lw.EXE", 3'b010, 7'b0001011, 3'b000, 2'b00, 4'b0000);
        ex("lw.MEM", 3'b011, 7'b0001011, 3'b000, 2'b00, 4'b1010);
        ex("lw.WB",  3'b100, 7'b1011011, 3'b000, 2'b00, 4'b0011);
        run(5);

        // sw: 4 cycles, no register write
        start("sw", T_SW, 1'b0);
        ex("sw.ID",  3'b001, 7'b0001011, 3'b000, 2'b00, 4'b0000);
        ex("sw.EXE", 3'b010, 7'b0001011, 3'b000, 2'b00, 4'b0000);
        ex("sw.MEM", 3'b011, 7'b1001011, 3'b000, 2'b00, 4'b0101);
        run(4);

        // beq taken / not taken
        start("beq_z1", T_BEQ, 1'b1);
        ex("beq_z1.ID",  3'b001, 7'b0001001, 3'b001, 2'b00, 4'b0000);
        ex("beq_z1.EXE", 3'b101, 7'b1001001, 3'b001, 2'b01, 4'b0001);
        run(3);
        start("beq_z0", T_BEQ, 1'b0);
        ex("beq_z0.ID",  3'b001, 7'b0001001, 3'b001, 2'b00, 4'b0000);
        ex("beq_z0.EXE", 3'b101, 7'b1001001, 3'b001, 2'b00, 4'b0001);
        run(3);

        // jumps: 2 cycles each
        start("jal", T_JAL, 1'b0);
        ex("jal.ID", 3'b001, 7'b1010001, 3'b000, 2'b11, 4'b0001);
        run(2);
        start("j", T_J, 1'b0);
        ex("j.ID", 3'b001, 7'b1001001, 3'b000, 2'b11, 4'b0001);
        run(2);
        start("jr", T_JR, 1'b0);
        ex("jr.ID", 3'b001, 7'b1001001, 3'b000, 2'b10, 4'b0001);
        run(2);

        // other ALU flavours: immediate zero-extend, slt, and
        alu_instr("ori", T_ORI, 7'b0001010, 3'b011);
        alu_instr("slt", T_SLT, 7'b0001101, 3'b010);
        alu_instr("and", T_AND, 7'b0001101, 3'b100);

        // halt: stuck with no enables for 10 cycles
        start("halt", T_HALT, 1'b0);
        ex("halt.ID", 3'b001, 7'b0001001, 3'b000, 2'b00, 4'b0000);
        for (int i = 0; i < 10; i++)
            ex("halt.hold", 3'b001, 7'b0001001, 3'b000, 2'b00, 4'b0000);
        run(12);

        // reset clears halt; illegal opcode is a 2-cycle no-op
        hold_reset(2);
        start("illegal", T_ILL, 1'b0);
        ex("illegal.ID", 3'b001, 7'b1001001, 3'b000, 2'b00, 4'b0001);
        run(2);
        alu_instr("add_end", T_ADD, 7'b0001101, 3'b000);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
